// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_if
//  Description : Bundle of the next-PC controller's datapath/fetch signals.
//                master : the sequencer (drives PC load, fetch request,
//                         flush and trap-capture outputs)
//                slave  : the surrounding core (program counter, imem,
//                         hazard and redirect sources)
//  Ports       : pc_cur, imem_req, imem_ready, stall, trap, jump,
//                jump_target, branch_taken, branch_target, pc_load_en,
//                pc_load_val, flush, epc, redirect_cnt
//                misalign (only with PC_SEQ_MISALIGN_CHECK_EN)
//  Options     : PC_SEQ_MISALIGN_CHECK_EN adds the misalign output
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_sequencer_if;
    logic [31:0] pc_cur;
    logic        imem_req;
    logic        imem_ready;
    logic        stall;
    logic        trap;
    logic        jump;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        pc_load_en;
    logic [31:0] pc_load_val;
    logic        flush;
    logic [31:0] epc;
    logic [15:0] redirect_cnt;
`ifdef PC_SEQ_MISALIGN_CHECK_EN
    logic        misalign;

    modport master (
        input  pc_cur, imem_ready, stall, trap, jump, jump_target,
               branch_taken, branch_target,
        output imem_req, pc_load_en, pc_load_val, flush, epc,
               redirect_cnt, misalign
    );

    modport slave (
        output pc_cur, imem_ready, stall, trap, jump, jump_target,
               branch_taken, branch_target,
        input  imem_req, pc_load_en, pc_load_val, flush, epc,
               redirect_cnt, misalign
    );
`else
    modport master (
        input  pc_cur, imem_ready, stall, trap, jump, jump_target,
               branch_taken, branch_target,
        output imem_req, pc_load_en, pc_load_val, flush, epc,
               redirect_cnt
    );

    modport slave (
        output pc_cur, imem_ready, stall, trap, jump, jump_target,
               branch_taken, branch_target,
        input  imem_req, pc_load_en, pc_load_val, flush, epc,
               redirect_cnt
    );
`endif
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Next-PC controller for the single-cycle core. Each cycle it
//                chooses increment (pc_load_en=0), hold (reload pc_cur) or a
//                redirect load (reset vector, trap vector, jump or branch
//                target), handshakes with imem and reports flush/trap info.
//  Ports       : clk      - rising-edge clock
//                reset_n  - asynchronous active-low reset
//                bus      - pc_sequencer_if.master (fetch/redirect/PC bus)
//  Parameters  : RESET_VECTOR - PC loaded after reset
//                TRAP_VECTOR  - PC loaded on trap
//  Options     : PC_SEQ_MISALIGN_CHECK_EN - misaligned jump/branch targets
//                become traps and pulse the registered misalign output
//  Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  wire            clk,
    input  wire            reset_n,
    pc_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_FETCH  = 2'd1,
        S_WAIT   = 2'd2,
        S_BUBBLE = 2'd3
    } state_t;

    localparam logic [1:0]  PRIO_BRANCH = 2'd1;
    localparam logic [1:0]  PRIO_JUMP   = 2'd2;
    localparam logic [1:0]  PRIO_TRAP   = 2'd3;
    localparam logic [15:0] CNT_MAX     = 16'hFFFF;

    state_t      state_q, state_d;

    logic        pend_valid_q, pend_valid_d;
    logic [1:0]  pend_prio_q,  pend_prio_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        pend_trap_q,  pend_trap_d;
    logic [31:0] epc_q;
    logic [15:0] redirect_cnt_q;

    // Decoded redirect request from the input pins this cycle
    logic        in_valid;
    logic [1:0]  in_prio;
    logic [31:0] in_target;
    logic        in_trap;

    // Redirect actually taken this cycle (from inputs or the pending register)
    logic        take;
    logic [31:0] sel_target;
    logic        sel_trap;

    logic        imem_req_w;
    logic        pc_load_en_w;
    logic [31:0] pc_load_val_w;
    logic        flush_w;

`ifdef PC_SEQ_MISALIGN_CHECK_EN
    logic        pend_mis_q, pend_mis_d;
    logic        in_mis;
    logic        sel_mis;
    logic        misalign_q;
`endif

    // ------------------------------------------------------------------
    // Redirect input decode, trap > jump > branch_taken. Priority follows
    // the source pin even when a misaligned target is turned into a trap.
    // ------------------------------------------------------------------
    always_comb begin
        in_valid  = 1'b0;
        in_prio   = 2'd0;
        in_target = pc_load_val_default();
        in_trap   = 1'b0;
`ifdef PC_SEQ_MISALIGN_CHECK_EN
        in_mis    = 1'b0;
`endif
        if (bus.trap) begin
            in_valid  = 1'b1;
            in_prio   = PRIO_TRAP;
            in_target = TRAP_VECTOR;
            in_trap   = 1'b1;
        end else if (bus.jump) begin
            in_valid  = 1'b1;
            in_prio   = PRIO_JUMP;
            in_target = bus.jump_target;
`ifdef PC_SEQ_MISALIGN_CHECK_EN
            if (bus.jump_target[1:0] != 2'b00) begin
                in_target = TRAP_VECTOR;
                in_trap   = 1'b1;
                in_mis    = 1'b1;
            end
`endif
        end else if (bus.branch_taken) begin
            in_valid  = 1'b1;
            in_prio   = PRIO_BRANCH;
            in_target = bus.branch_target;
`ifdef PC_SEQ_MISALIGN_CHECK_EN
            if (bus.branch_target[1:0] != 2'b00) begin
                in_target = TRAP_VECTOR;
                in_trap   = 1'b1;
                in_mis    = 1'b1;
            end
`endif
        end
    end

    function automatic logic [31:0] pc_load_val_default();
        return TRAP_VECTOR;
    endfunction

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        imem_req_w    = 1'b0;
        pc_load_en_w  = 1'b1;          // hold unless told otherwise
        pc_load_val_w = bus.pc_cur;
        flush_w       = 1'b0;
        take          = 1'b0;
        sel_target    = in_target;
        sel_trap      = in_trap;
        pend_valid_d  = pend_valid_q;
        pend_prio_d   = pend_prio_q;
        pend_target_d = pend_target_q;
        pend_trap_d   = pend_trap_q;
`ifdef PC_SEQ_MISALIGN_CHECK_EN
        sel_mis       = in_mis;
        pend_mis_d    = pend_mis_q;
`endif

        case (state_q)
            S_BOOT: begin
                pc_load_val_w = RESET_VECTOR;
                flush_w       = 1'b1;
                state_d       = S_FETCH;
            end

            S_FETCH: begin
                imem_req_w = 1'b1;
                if (in_valid) begin
                    take = 1'b1;
                end else if (!bus.imem_ready) begin
                    state_d = S_WAIT;
                end else if (!bus.stall) begin
                    pc_load_en_w = 1'b0;
                end
            end

            S_WAIT: begin
                imem_req_w = 1'b1;
                if (bus.imem_ready) begin
                    if (pend_valid_q) begin
                        take         = 1'b1;
                        sel_target   = pend_target_q;
                        sel_trap     = pend_trap_q;
`ifdef PC_SEQ_MISALIGN_CHECK_EN
                        sel_mis      = pend_mis_q;
`endif
                        pend_valid_d = 1'b0;
                    end else if (in_valid) begin
                        take = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        if (!bus.stall) begin
                            pc_load_en_w = 1'b0;
                        end
                    end
                end else if (in_valid && (!pend_valid_q || (in_prio > pend_prio_q))) begin
                    // Only a strictly higher priority request replaces a pending one
                    pend_valid_d  = 1'b1;
                    pend_prio_d   = in_prio;
                    pend_target_d = in_target;
                    pend_trap_d   = in_trap;
`ifdef PC_SEQ_MISALIGN_CHECK_EN
                    pend_mis_d    = in_mis;
`endif
                end
            end

            S_BUBBLE: begin
                state_d = S_FETCH;
            end

            default: begin
                state_d = S_BOOT;
            end
        endcase

        if (take) begin
            pc_load_en_w  = 1'b1;
            pc_load_val_w = sel_target;
            flush_w       = 1'b1;
            state_d       = S_BUBBLE;
        end
    end

    // ------------------------------------------------------------------
    // State, pending redirect and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_BOOT;
            pend_valid_q   <= 1'b0;
            pend_prio_q    <= 2'd0;
            pend_target_q  <= 32'd0;
            pend_trap_q    <= 1'b0;
            epc_q          <= 32'd0;
            redirect_cnt_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_prio_q   <= pend_prio_d;
            pend_target_q <= pend_target_d;
            pend_trap_q   <= pend_trap_d;
            // PC is held in WAIT, so pc_cur still names the trapping fetch
            if (take && sel_trap) begin
                epc_q <= bus.pc_cur;
            end
            if (take && (redirect_cnt_q != CNT_MAX)) begin
                redirect_cnt_q <= redirect_cnt_q + 16'd1;
            end
        end
    end

`ifdef PC_SEQ_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_mis_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pend_mis_q <= pend_mis_d;
            misalign_q <= take && sel_mis;
        end
    end

    assign bus.misalign = misalign_q;
`endif

    assign bus.imem_req     = imem_req_w;
    assign bus.pc_load_en   = pc_load_en_w;
    assign bus.pc_load_val  = pc_load_val_w;
    assign bus.flush        = flush_w;
    assign bus.epc          = epc_q;
    assign bus.redirect_cnt = redirect_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Directed self-checking bench for pc_sequencer. A small
//                program_counter model closes the loop on pc_cur; inputs
//                change just after the rising edge and outputs are sampled
//                on the falling edge.
//  Options     : PC_SEQ_MISALIGN_CHECK_EN enables the misalign scenario
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk;
    logic        reset_n;
    logic [31:0] r_pc;
    int          n_cmp;
    int          n_err;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // program_counter model: load when load_en, else +4
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= 32'd0;
        end else if (bus.pc_load_en) begin
            r_pc <= bus.pc_load_val;
        end else begin
            r_pc <= r_pc + 32'd4;
        end
    end

    assign bus.pc_cur = r_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic look;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        bus.imem_ready    = 1'b1;
        bus.stall         = 1'b0;
        bus.trap          = 1'b0;
        bus.jump          = 1'b0;
        bus.jump_target   = 32'd0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'd0;

        // ---- reset values ----
        repeat (2) @(posedge clk);
        look;
        chk("rst_load_en", 32'(bus.pc_load_en), 32'd1);
        chk("rst_load_val", bus.pc_load_val, 32'h0);
        chk("rst_flush", 32'(bus.flush), 32'd1);
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_epc", bus.epc, 32'h0);
        chk("rst_cnt", 32'(bus.redirect_cnt), 32'd0);
`ifdef PC_SEQ_MISALIGN_CHECK_EN
        chk("rst_misalign", 32'(bus.misalign), 32'd0);
`endif
        step;
        reset_n = 1'b1;

        // ---- boot then sequential fetch ----
        look;                                   // BOOT
        chk("boot_pc", r_pc, 32'h0);
        chk("boot_flush", 32'(bus.flush), 32'd1);
        chk("boot_req", 32'(bus.imem_req), 32'd0);
        step;
        look;                                   // first FETCH
        chk("f0_pc", r_pc, 32'h0);
        chk("f0_flush", 32'(bus.flush), 32'd0);
        chk("f0_req", 32'(bus.imem_req), 32'd1);
        chk("f0_load_en", 32'(bus.pc_load_en), 32'd0);
        step;
        look;
        chk("f1_pc", r_pc, 32'h4);
        step;

        // ---- branch to 0x40 at PC 0x8 ----
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h40;
        look;
        chk("br_pc", r_pc, 32'h8);
        chk("br_load_val", bus.pc_load_val, 32'h40);
        chk("br_flush", 32'(bus.flush), 32'd1);
        step;
        bus.branch_taken = 1'b0;
        look;                                   // BUBBLE
        chk("br_bub_pc", r_pc, 32'h40);
        chk("br_bub_req", 32'(bus.imem_req), 32'd0);
        chk("br_bub_flush", 32'(bus.flush), 32'd0);
        chk("br_bub_hold", bus.pc_load_val, 32'h40);
        chk("br_cnt", 32'(bus.redirect_cnt), 32'd1);
        step;
        look;
        chk("br_fetch_pc", r_pc, 32'h40);
        chk("br_fetch_req", 32'(bus.imem_req), 32'd1);
        step;

        // ---- jump to 0x10, trap ignored in BUBBLE ----
        bus.jump = 1'b1;
        bus.jump_target = 32'h10;
        look;
        chk("j10_pc", r_pc, 32'h44);
        step;
        bus.jump = 1'b0;
        bus.trap = 1'b1;
        look;
        chk("bub_ign_val", bus.pc_load_val, 32'h10);
        chk("bub_ign_flush", 32'(bus.flush), 32'd0);
        step;

        // ---- trap + jump together at PC 0x10 ----
        bus.jump = 1'b1;
        bus.jump_target = 32'h80;
        look;
        chk("tj_pc", r_pc, 32'h10);
        chk("tj_epc_before", bus.epc, 32'h0);
        chk("tj_load_val", bus.pc_load_val, 32'h100);
        step;
        bus.trap = 1'b0;
        bus.jump = 1'b0;
        look;
        chk("tj_pc_after", r_pc, 32'h100);
        chk("tj_epc", bus.epc, 32'h10);
        chk("tj_cnt", 32'(bus.redirect_cnt), 32'd3);
        step;

        // ---- jump to 0xC, then imem_ready low 3 cycles ----
        bus.jump = 1'b1;
        bus.jump_target = 32'hC;
        look;
        step;
        bus.jump = 1'b0;
        look;
        step;                                   // BUBBLE
        bus.imem_ready = 1'b0;
        look;                                   // FETCH, not ready
        chk("w1_pc", r_pc, 32'hC);
        chk("w1_load_en", 32'(bus.pc_load_en), 32'd1);
        chk("w1_load_val", bus.pc_load_val, 32'hC);
        step;
        bus.jump = 1'b1;
        bus.jump_target = 32'h200;
        look;                                   // WAIT, jump latched
        chk("w2_pc", r_pc, 32'hC);
        chk("w2_flush", 32'(bus.flush), 32'd0);
        chk("w2_req", 32'(bus.imem_req), 32'd1);
        step;
        bus.jump = 1'b0;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h300;
        look;                                   // lower priority branch
        chk("w3_pc", r_pc, 32'hC);
        chk("w3_load_val", bus.pc_load_val, 32'hC);
        step;
        bus.branch_taken = 1'b0;
        bus.imem_ready = 1'b1;
        look;
        chk("w4_pc", r_pc, 32'hC);
        chk("w4_load_val", bus.pc_load_val, 32'h200);
        chk("w4_flush", 32'(bus.flush), 32'd1);
        step;
        look;
        chk("w5_pc", r_pc, 32'h200);
        chk("w5_cnt", 32'(bus.redirect_cnt), 32'd5);
        step;

        // ---- jump to 0x14, then stall 2 cycles ----
        bus.jump = 1'b1;
        bus.jump_target = 32'h14;
        look;
        step;
        bus.jump = 1'b0;
        look;
        step;
        bus.stall = 1'b1;
        look;
        chk("st1_pc", r_pc, 32'h14);
        step;
        look;
        chk("st2_pc", r_pc, 32'h14);
        step;
        bus.stall = 1'b0;
        look;
        chk("st3_pc", r_pc, 32'h14);
        step;
        look;
        chk("st4_pc", r_pc, 32'h18);

        // ---- stall + not ready -> WAIT; branch then trap overwrites ----
        step;
        bus.stall = 1'b1;
        bus.imem_ready = 1'b0;
        look;
        chk("sw_pc", r_pc, 32'h1C);
        chk("sw_load_en", 32'(bus.pc_load_en), 32'd1);
        step;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h300;
        look;
        chk("sw_hold_pc", r_pc, 32'h1C);
        step;
        bus.branch_taken = 1'b0;
        bus.trap = 1'b1;
        look;
        chk("sw_trap_hold", bus.pc_load_val, 32'h1C);
        step;
        bus.trap = 1'b0;
        bus.imem_ready = 1'b1;
        bus.stall = 1'b0;
        look;
        chk("sw_load_val", bus.pc_load_val, 32'h100);
        chk("sw_flush", 32'(bus.flush), 32'd1);
        step;
        look;
        chk("sw_pc_after", r_pc, 32'h100);
        chk("sw_epc", bus.epc, 32'h1C);
        chk("sw_cnt", 32'(bus.redirect_cnt), 32'd7);
        step;

        // ---- reset asserted mid-WAIT with a pending redirect ----
        bus.imem_ready = 1'b0;
        look;
        step;                                   // now WAIT
        bus.jump = 1'b1;
        bus.jump_target = 32'h400;
        look;
        step;                                   // pending latched
        bus.jump = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("ar_load_en", 32'(bus.pc_load_en), 32'd1);
        chk("ar_load_val", bus.pc_load_val, 32'h0);
        chk("ar_flush", 32'(bus.flush), 32'd1);
        chk("ar_req", 32'(bus.imem_req), 32'd0);
        chk("ar_epc", bus.epc, 32'h0);
        chk("ar_cnt", 32'(bus.redirect_cnt), 32'd0);
        step;
        reset_n = 1'b1;
        look;                                   // BOOT
        chk("ar_boot_flush", 32'(bus.flush), 32'd1);
        step;
        look;                                   // FETCH not ready
        step;
        look;                                   // WAIT not ready
        step;
        bus.imem_ready = 1'b1;
        look;                                   // WAIT ready, no stale pending
        chk("ar_no_pend_en", 32'(bus.pc_load_en), 32'd0);
        chk("ar_no_pend_flush", 32'(bus.flush), 32'd0);
        step;
        look;
        chk("ar_pc_inc", r_pc, 32'h4);

`ifdef PC_SEQ_MISALIGN_CHECK_EN
        // ---- misaligned jump becomes trap ----
        step;
        bus.jump = 1'b1;
        bus.jump_target = 32'h20;
        look;
        step;
        bus.jump = 1'b0;
        look;
        step;                                   // BUBBLE
        bus.jump = 1'b1;
        bus.jump_target = 32'h102;
        look;
        chk("mis_pc", r_pc, 32'h20);
        chk("mis_load_val", bus.pc_load_val, 32'h100);
        step;
        bus.jump = 1'b0;
        look;
        chk("mis_pc_after", r_pc, 32'h100);
        chk("mis_epc", bus.epc, 32'h20);
        chk("mis_pulse", 32'(bus.misalign), 32'd1);
        step;
        look;
        chk("mis_clear", 32'(bus.misalign), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
